rst_seq_ctrl: RTL and testbench

- Reset consumer/sequencer for the UART-to-AXI interface.
- Takes the raw asynchronous system reset and a software reset request.
- Produces synchronized, staged active-low resets: the AXI side is released first, then the UART side after a gap.
- Reports when the sequence has completed.
- Sits between the top-level reset source and the AXI master / UART core reset pins.

---
 rtl/rst_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_rst_seq_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rst_seq_ctrl.sv
// Staged reset sequencer: synchronized release of AXI reset, then UART reset.
// Optional RST_SEQ_CNT_EN adds a saturating completed-sequence counter.
module rst_seq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 16,
    parameter int unsigned STAGE_GAP   = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Soft_Rst_Req,
`ifdef RST_SEQ_CNT_EN
    input  logic       Rst_Count_Clr,
    output logic [7:0] Rst_Count,
`endif
    output logic       Axi_Rst_n,
    output logic       Uart_Rst_n,
    output logic       Rst_Done,
    output logic       Rst_Busy
);

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LAST  = 8'(STAGE_GAP - 1);

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        GAP  = 2'd1,
        DONE = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rst_int;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       axi_q, axi_d;
    logic       uart_q, uart_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign rst_int = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            axi_q   <= 1'b0;
            uart_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            axi_q   <= axi_d;
            uart_q  <= uart_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        axi_d   = axi_q;
        uart_d  = uart_q;
        done_d  = done_q;
        busy_d  = busy_q;
        // FSM is frozen in its reset state until the synchronized release
        if (rst_int) begin
            state_d = HOLD;
            cnt_d   = '0;
            axi_d   = 1'b0;
            uart_d  = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = GAP;
                        cnt_d   = '0;
                        axi_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = DONE;
                        cnt_d   = '0;
                        uart_d  = 1'b1;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    if (Soft_Rst_Req) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        axi_d   = 1'b0;
                        uart_d  = 1'b0;
                        done_d  = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    axi_d   = 1'b0;
                    uart_d  = 1'b0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            endcase
        end
    end

    assign Axi_Rst_n  = axi_q;
    assign Uart_Rst_n = uart_q;
    assign Rst_Done   = done_q;
    assign Rst_Busy   = busy_q;

`ifdef RST_SEQ_CNT_EN
    logic [7:0] seq_cnt_q, seq_cnt_d;
    logic       done_entry;

    assign done_entry = (state_q == GAP) && (state_d == DONE);

    always_comb begin
        seq_cnt_d = seq_cnt_q;
        if (Rst_Count_Clr) begin
            seq_cnt_d = '0;
        end else if (done_entry && (seq_cnt_q != 8'hFF)) begin
            seq_cnt_d = seq_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            seq_cnt_q <= '0;
        end else begin
            seq_cnt_q <= seq_cnt_d;
        end
    end

    assign Rst_Count = seq_cnt_q;
`endif

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl; exercises RST_SEQ_CNT_EN when defined.
module tb_rst_seq_ctrl;

    logic       Clk;
    logic       Rst;
    logic       Soft_Rst_Req;
    logic       Axi_Rst_n;
    logic       Uart_Rst_n;
    logic       Rst_Done;
    logic       Rst_Busy;
`ifdef RST_SEQ_CNT_EN
    logic       Rst_Count_Clr;
    logic [7:0] Rst_Count;
`endif

    int total;
    int bad;

    rst_seq_ctrl #(
        .SYNC_STAGES(2),
        .HOLD_CYCLES(16),
        .STAGE_GAP  (4)
    ) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .Soft_Rst_Req(Soft_Rst_Req),
`ifdef RST_SEQ_CNT_EN
        .Rst_Count_Clr(Rst_Count_Clr),
        .Rst_Count   (Rst_Count),
`endif
        .Axi_Rst_n   (Axi_Rst_n),
        .Uart_Rst_n  (Uart_Rst_n),
        .Rst_Done    (Rst_Done),
        .Rst_Busy    (Rst_Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // outputs are packed as {Axi, Uart, Done, Busy}
    localparam logic [3:0] S_RST  = 4'b0001;
    localparam logic [3:0] S_AXI  = 4'b1001;
    localparam logic [3:0] S_DONE = 4'b1110;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] outs();
        return {4'b0, Axi_Rst_n, Uart_Rst_n, Rst_Done, Rst_Busy};
    endfunction

    task automatic soft_pulse();
        Soft_Rst_Req = 1'b1;
        tick(1);
        Soft_Rst_Req = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        Rst          = 1'b1;
        Soft_Rst_Req = 1'b0;
`ifdef RST_SEQ_CNT_EN
        Rst_Count_Clr = 1'b0;
`endif

        // power-on
        tick(5);
        check("por_rst", outs(), {4'b0, S_RST});
        Rst = 1'b0;
        tick(17);
        check("por_pre_axi", outs(), {4'b0, S_RST});
        tick(1);
        check("por_axi", outs(), {4'b0, S_AXI});
        tick(3);
        check("por_pre_uart", outs(), {4'b0, S_AXI});
        tick(1);
        check("por_done", outs(), {4'b0, S_DONE});

        // async glitch in DONE, shorter than a clock period
        tick(3);
        #2;
        Rst = 1'b1;
        #1;
        check("async_assert", outs(), {4'b0, S_RST});
        #1;
        Rst = 1'b0;
        tick(17);
        check("async_pre_axi", outs(), {4'b0, S_RST});
        tick(1);
        check("async_axi", outs(), {4'b0, S_AXI});
        tick(4);
        check("async_done", outs(), {4'b0, S_DONE});

        // soft reset from DONE
        tick(2);
        soft_pulse();
        check("soft_assert", outs(), {4'b0, S_RST});
        tick(15);
        check("soft_pre_axi", outs(), {4'b0, S_RST});
        tick(1);
        check("soft_axi", outs(), {4'b0, S_AXI});
        tick(3);
        check("soft_pre_uart", outs(), {4'b0, S_AXI});
        tick(1);
        check("soft_done", outs(), {4'b0, S_DONE});

        // requests during HOLD (cycle 8) and GAP are ignored
        soft_pulse();
        tick(7);
        soft_pulse();
        tick(7);
        check("ign_pre_axi", outs(), {4'b0, S_RST});
        tick(1);
        check("ign_axi", outs(), {4'b0, S_AXI});
        soft_pulse();
        tick(2);
        check("ign_gap", outs(), {4'b0, S_AXI});
        tick(1);
        check("ign_done", outs(), {4'b0, S_DONE});

        // Rst two cycles into GAP
        soft_pulse();
        tick(16);
        check("gap_axi", outs(), {4'b0, S_AXI});
        tick(2);
        Rst = 1'b1;
        #1;
        check("gap_rst", outs(), {4'b0, S_RST});
        tick(2);
        Rst = 1'b0;
        tick(17);
        check("gap_pre_axi", outs(), {4'b0, S_RST});
        tick(1);
        check("gap_re_axi", outs(), {4'b0, S_AXI});
        tick(3);
        check("gap_pre_uart", outs(), {4'b0, S_AXI});
        tick(1);
        check("gap_done", outs(), {4'b0, S_DONE});

`ifdef RST_SEQ_CNT_EN
        // Rst above cleared the counter; one sequence since then
        check("cnt_after_rst", Rst_Count, 8'd1);
        repeat (3) begin
            soft_pulse();
            tick(20);
        end
        check("cnt_four", Rst_Count, 8'd4);
        soft_pulse();
        check("cnt_kept_soft", Rst_Count, 8'd4);
        tick(19);
        Rst_Count_Clr = 1'b1;
        tick(1);
        Rst_Count_Clr = 1'b0;
        check("cnt_clr_done", outs(), {4'b0, S_DONE});
        check("cnt_clr_prio", Rst_Count, 8'd0);
        repeat (300) begin
            soft_pulse();
            tick(20);
        end
        check("cnt_sat", Rst_Count, 8'd255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
